uart_ram_loader: RTL and testbench

//  Serial front end of the memory bus. In load mode it receives 8N1 bytes on Rx_Serial,

---
 rtl/uart_ram_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// UART front end of the memory bus: loads IM/DM words from Rx_Serial, dumps DM words on Tx_Serial.
// Define UART_PARITY_EN for 8E1 framing on both directions; the default build is 8N1.
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int IM_SIZE_BIT  = 10,
    parameter int DM_SIZE_BIT  = 10,
    parameter int MAX_SIZE_BIT = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    ram_id,
    input  logic                    Rx_Serial,
    input  logic [31:0]             data_to_send,
    output logic [MAX_SIZE_BIT-1:0] address,
    output logic                    on_received,
    output logic [31:0]             recv_data,
    output logic                    Tx_Serial,
    output logic                    IM_Done,
    output logic                    DM_Done
);
    localparam int                      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]        BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]        HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [MAX_SIZE_BIT-1:0] IM_LAST   = MAX_SIZE_BIT'((1 << IM_SIZE_BIT) - 1);
    localparam logic [MAX_SIZE_BIT-1:0] DM_LAST   = MAX_SIZE_BIT'((1 << DM_SIZE_BIT) - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LATCH, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LATCH, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

    logic                    r_rx_meta, r_rx_sync, r_rx_prev;
    logic                    r_mode_d, r_ram_d;
    rx_state_t               r_rx_state;
    logic [CNT_W-1:0]        r_rx_cnt;
    logic [2:0]              r_rx_bit;
    logic [7:0]              r_rx_shift;
    logic                    r_byte_valid;
`ifdef UART_PARITY_EN
    logic                    r_rx_par_ok;
`endif
    tx_state_t               r_tx_state;
    logic [CNT_W-1:0]        r_tx_cnt;
    logic [2:0]              r_tx_bit;
    logic [31:0]             r_tx_word;
    logic                    r_tx_last;
    logic [1:0]              r_lane;
    logic                    r_finished;

    logic                    w_rx_fall, w_cfg_chg, w_load_run, w_dump_run, w_stop_ok;
    logic [MAX_SIZE_BIT-1:0] w_word_last;
    logic [7:0]              w_tx_byte;

    assign w_rx_fall   = r_rx_prev & ~r_rx_sync;
    // A mode or RAM change acts as a one-cycle abort so the new transfer starts clean.
    assign w_cfg_chg   = (mode != r_mode_d) || (ram_id != r_ram_d);
    assign w_load_run  = en & ~mode & ~w_cfg_chg;
    assign w_dump_run  = en & mode & ram_id & ~w_cfg_chg;
    assign w_word_last = ram_id ? DM_LAST : IM_LAST;
    assign w_tx_byte   = r_tx_word[{r_lane, 3'b000} +: 8];
`ifdef UART_PARITY_EN
    assign w_stop_ok   = r_rx_sync & r_rx_par_ok;
`else
    assign w_stop_ok   = r_rx_sync;
`endif

    // NOTE: Rx_Serial is asynchronous; two flops bound metastability before any decision uses it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= Rx_Serial;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_ok  <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            if (!w_load_run) begin
                r_rx_state <= RX_IDLE;
                r_rx_cnt   <= '0;
            end else begin
                unique case (r_rx_state)
                    RX_IDLE: if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                    RX_START: if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    RX_DATA: if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
`ifdef UART_PARITY_EN
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_PARITY;
`else
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
`endif
                    end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
`ifdef UART_PARITY_EN
                    RX_PARITY: if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt    <= '0;
                        r_rx_par_ok <= (r_rx_sync == ^r_rx_shift);
                        r_rx_state  <= RX_STOP;
                    end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
`endif
                    RX_STOP: if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt     <= '0;
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= w_stop_ok;
                    end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address     <= '0;
            on_received <= 1'b0;
            recv_data   <= '0;
            Tx_Serial   <= 1'b1;
            IM_Done     <= 1'b0;
            DM_Done     <= 1'b0;
            r_mode_d    <= 1'b0;
            r_ram_d     <= 1'b0;
            r_lane      <= '0;
            r_finished  <= 1'b0;
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_word   <= '0;
            r_tx_last   <= 1'b0;
        end else begin
            r_mode_d    <= mode;
            r_ram_d     <= ram_id;
            on_received <= 1'b0;
            if (!w_load_run && !w_dump_run) begin
                address    <= '0;
                r_lane     <= '0;
                r_finished <= 1'b0;
                r_tx_state <= TX_IDLE;
                r_tx_cnt   <= '0;
                Tx_Serial  <= 1'b1;
            end else if (w_load_run) begin
                if (on_received) begin
                    if (address == w_word_last) begin
                        address    <= '0;
                        r_finished <= 1'b1;
                        if (ram_id) DM_Done <= 1'b1;
                        else        IM_Done <= 1'b1;
                    end else address <= address + MAX_SIZE_BIT'(1);
                end
                if (r_byte_valid && !r_finished) begin
                    recv_data[{r_lane, 3'b000} +: 8] <= r_rx_shift;
                    r_lane <= r_lane + 2'd1;
                    if (r_lane == 2'd3) on_received <= 1'b1;
                end
            end else begin
                unique case (r_tx_state)
                    TX_IDLE: if (!r_finished) r_tx_state <= TX_LATCH;
                    TX_LATCH: begin
                        r_tx_word  <= data_to_send;
                        r_lane     <= '0;
                        r_tx_cnt   <= '0;
                        Tx_Serial  <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                    TX_START: if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        Tx_Serial  <= w_tx_byte[0];
                        r_tx_state <= TX_DATA;
                    end else r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    TX_DATA: if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            Tx_Serial  <= ^w_tx_byte;
                            r_tx_state <= TX_PARITY;
`else
                            Tx_Serial  <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else Tx_Serial <= w_tx_byte[r_tx_bit + 3'd1];
                    end else r_tx_cnt <= r_tx_cnt + CNT_W'(1);
`ifdef UART_PARITY_EN
                    TX_PARITY: if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        Tx_Serial  <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end else r_tx_cnt <= r_tx_cnt + CNT_W'(1);
`endif
                    TX_STOP: begin
                        // The next word is fetched inside the last stop bit so bytes stay gap-free.
                        if (r_tx_cnt == '0 && r_lane == 2'd3) begin
                            r_tx_last <= (address == DM_LAST);
                            if (address != DM_LAST) address <= address + MAX_SIZE_BIT'(1);
                        end
                        if (r_tx_cnt == CNT_W'(1) && r_lane == 2'd3 && !r_tx_last)
                            r_tx_word <= data_to_send;
                        if (r_tx_cnt == BIT_LAST) begin
                            r_tx_cnt <= '0;
                            if (r_lane == 2'd3 && r_tx_last) begin
                                DM_Done    <= 1'b1;
                                r_finished <= 1'b1;
                                address    <= '0;
                                r_tx_state <= TX_IDLE;
                            end else begin
                                r_lane     <= r_lane + 2'd1;
                                Tx_Serial  <= 1'b0;
                                r_tx_state <= TX_START;
                            end
                        end else r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_ram_loader.sv
// Self-checking bench for uart_ram_loader: UART byte driver, strobe scoreboard and TX frame decoder.
module tb_uart_ram_loader;
    localparam int CPB = 8;
    localparam int IMB = 2;
    localparam int DMB = 1;
    localparam int MSB = 3;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic           clk;
    logic           reset, en, mode, ram_id, Rx_Serial;
    logic [31:0]    data_to_send;
    logic [MSB-1:0] address;
    logic           on_received;
    logic [31:0]    recv_data;
    logic           Tx_Serial, IM_Done, DM_Done;

    logic [31:0]    tb_dm [2];
    logic [MSB-1:0] q_addr [$];
    logic [31:0]    q_data [$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int unsigned    cyc      = 0;

    uart_ram_loader #(
        .CLKS_PER_BIT(CPB), .IM_SIZE_BIT(IMB), .DM_SIZE_BIT(DMB), .MAX_SIZE_BIT(MSB)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .ram_id(ram_id),
        .Rx_Serial(Rx_Serial), .data_to_send(data_to_send), .address(address),
        .on_received(on_received), .recv_data(recv_data), .Tx_Serial(Tx_Serial),
        .IM_Done(IM_Done), .DM_Done(DM_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_to_send = tb_dm[address[DMB-1:0]];

    // Every write strobe seen by the bus is recorded with its address and word.
    always @(negedge clk) begin
        if (on_received === 1'b1) begin
            q_addr.push_back(address);
            q_data.push_back(recv_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no summary by 500000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] pack_le(input logic [7:0] b0, b1, b2, b3);
        return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
    endfunction

    task automatic drive_bit(input logic v);
        Rx_Serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    // One frame plus one idle bit; without parity a bad-parity request corrupts the stop bit instead.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ bad_par);
        drive_bit(!bad_stop);
`else
        drive_bit(!(bad_stop || bad_par));
`endif
        drive_bit(1'b1);
    endtask

    task automatic restart(input logic m, input logic r);
        en = 1'b0;
        repeat (3) @(negedge clk);
        mode = m;
        ram_id = r;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic tx_get_byte(output logic [7:0] b, output int unsigned t0, output bit ok);
        int n = 0;
        ok = 1'b1;
        b  = '0;
        while (Tx_Serial !== 1'b0 && n < 40 * CPB) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        if (Tx_Serial !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        if (Tx_Serial !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = Tx_Serial;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (Tx_Serial !== ^b) ok = 1'b0;
`endif
        repeat (CPB) @(negedge clk);
        if (Tx_Serial !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        #3 reset = 1'b0;
        #1;
        n_checks++; if (address !== '0) begin n_fail++; $display("FAIL %s address: got %h expected 0", tag, address); end
        n_checks++; if (on_received !== 1'b0) begin n_fail++; $display("FAIL %s on_received: got %b expected 0", tag, on_received); end
        n_checks++; if (recv_data !== 32'h0) begin n_fail++; $display("FAIL %s recv_data: got %h expected 0", tag, recv_data); end
        n_checks++; if (Tx_Serial !== 1'b1) begin n_fail++; $display("FAIL %s Tx_Serial: got %b expected 1", tag, Tx_Serial); end
        n_checks++; if (IM_Done !== 1'b0) begin n_fail++; $display("FAIL %s IM_Done: got %b expected 0", tag, IM_Done); end
        n_checks++; if (DM_Done !== 1'b0) begin n_fail++; $display("FAIL %s DM_Done: got %b expected 0", tag, DM_Done); end
        repeat (2) @(negedge clk);
        en = 1'b0;
        Rx_Serial = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load_im();
        logic [7:0]  b [16];
        logic [31:0] exp;
        b[0] = 8'h78; b[1] = 8'h56; b[2] = 8'h34; b[3] = 8'h12;
        for (int i = 4; i < 16; i++) b[i] = 8'($urandom);
        restart(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 12) begin
                n_checks++; if (IM_Done !== 1'b0) begin n_fail++; $display("FAIL load_im_done_early: got %b expected 0", IM_Done); end
            end
            send_byte(b[i], 1'b0, 1'b0);
        end
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL load_im_strobes: got %0d expected 4", q_data.size()); end
        for (int w = 0; w < 4 && w < q_data.size(); w++) begin
            exp = pack_le(b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]);
            n_checks++; if (q_addr[w] !== MSB'(w)) begin n_fail++; $display("FAIL load_im_addr%0d: got %0d expected %0d", w, q_addr[w], w); end
            n_checks++; if (q_data[w] !== exp) begin n_fail++; $display("FAIL load_im_data%0d: got %h expected %h", w, q_data[w], exp); end
        end
        n_checks++; if (IM_Done !== 1'b1) begin n_fail++; $display("FAIL load_im_done: got %b expected 1", IM_Done); end
        n_checks++; if (DM_Done !== 1'b0) begin n_fail++; $display("FAIL load_im_dm_done: got %b expected 0", DM_Done); end
        n_checks++; if (address !== '0) begin n_fail++; $display("FAIL load_im_wrap: got %0d expected 0", address); end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL load_im_after_done: got %0d strobes expected 4", q_data.size()); end
    endtask

    task automatic test_framing();
        restart(1'b0, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        n_checks++; if (q_data.size() != 0) begin n_fail++; $display("FAIL framing_no_strobe: got %0d strobes expected 0", q_data.size()); end
        send_byte(8'hCC, 1'b0, 1'b0);
        n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL framing_strobe: got %0d strobes expected 1", q_data.size()); end
        else begin
            n_checks++; if (q_data[0] !== 32'hCCBBAA11) begin n_fail++; $display("FAIL framing_data: got %h expected ccbbaa11", q_data[0]); end
            n_checks++; if (q_addr[0] !== '0) begin n_fail++; $display("FAIL framing_addr: got %0d expected 0", q_addr[0]); end
        end
    endtask

    task automatic test_glitch();
        logic [7:0]  b [4];
        logic [31:0] exp;
        restart(1'b0, 1'b1);
        Rx_Serial = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        Rx_Serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            send_byte(b[i], 1'b0, 1'b0);
        end
        exp = pack_le(b[0], b[1], b[2], b[3]);
        n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 1", q_data.size()); end
        else begin
            n_checks++; if (q_data[0] !== exp) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", q_data[0], exp); end
        end
    endtask

    task automatic test_abort();
        logic [7:0]  b [4];
        logic [31:0] exp;
        restart(1'b0, 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            send_byte(b[i], 1'b0, 1'b0);
        end
        exp = pack_le(b[0], b[1], b[2], b[3]);
        n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL abort_strobes: got %0d expected 1", q_data.size()); end
        else begin
            n_checks++; if (q_data[0] !== exp) begin n_fail++; $display("FAIL abort_data: got %h expected %h", q_data[0], exp); end
            n_checks++; if (q_addr[0] !== '0) begin n_fail++; $display("FAIL abort_addr: got %0d expected 0", q_addr[0]); end
        end
        n_checks++; if (address !== MSB'(1)) begin n_fail++; $display("FAIL abort_next_addr: got %0d expected 1", address); end
        n_checks++; if (IM_Done !== 1'b1) begin n_fail++; $display("FAIL abort_im_done_kept: got %b expected 1", IM_Done); end
    endtask

    task automatic test_random_load();
        logic [7:0]  acc [$];
        logic [7:0]  b;
        logic [31:0] exp;
        bit          bad;
        int          guard = 0;
        restart(1'b0, 1'b1);
        while (acc.size() < 8 && guard < 40) begin
            b   = 8'($urandom);
            bad = ($urandom_range(3) == 0);
            if (bad) begin
                if ($urandom_range(1) == 0) send_byte(b, 1'b1, 1'b0);
                else                        send_byte(b, 1'b0, 1'b1);
            end else begin
                if (acc.size() == 7) begin
                    n_checks++; if (DM_Done !== 1'b0) begin n_fail++; $display("FAIL rand_dm_done_early: got %b expected 0", DM_Done); end
                    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL rand_mid_strobes: got %0d expected 1", q_data.size()); end
                end
                send_byte(b, 1'b0, 1'b0);
                acc.push_back(b);
            end
            guard++;
        end
        n_checks++; if (q_data.size() != 2) begin n_fail++; $display("FAIL rand_strobes: got %0d expected 2", q_data.size()); end
        for (int w = 0; w < 2 && w < q_data.size() && 4*w+3 < acc.size(); w++) begin
            exp = pack_le(acc[4*w], acc[4*w+1], acc[4*w+2], acc[4*w+3]);
            n_checks++; if (q_addr[w] !== MSB'(w)) begin n_fail++; $display("FAIL rand_addr%0d: got %0d expected %0d", w, q_addr[w], w); end
            n_checks++; if (q_data[w] !== exp) begin n_fail++; $display("FAIL rand_data%0d: got %h expected %h", w, q_data[w], exp); end
        end
        n_checks++; if (DM_Done !== 1'b1) begin n_fail++; $display("FAIL rand_dm_done: got %b expected 1", DM_Done); end
        n_checks++; if (address !== '0) begin n_fail++; $display("FAIL rand_wrap: got %0d expected 0", address); end
    endtask

    task automatic test_reset_mid_dump();
        int n = 0;
        tb_dm[0] = $urandom;
        tb_dm[1] = $urandom;
        restart(1'b1, 1'b1);
        n_checks++; if ({IM_Done, DM_Done} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_flags: got %b expected 11", {IM_Done, DM_Done}); end
        while (Tx_Serial !== 1'b0 && n < 10 * CPB) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (Tx_Serial !== 1'b0) begin n_fail++; $display("FAIL pre_reset_tx_start: got %b expected 0", Tx_Serial); end
        repeat (3 * CPB) @(negedge clk);
        test_reset("reset_mid");
    endtask

    task automatic test_dump(input bit fixed);
        logic [7:0]  b, exp;
        int unsigned t0, t_prev;
        bit          ok;
        int          zeros = 0;
        if (fixed) begin
            tb_dm[0] = 32'hDEADBEEF;
            tb_dm[1] = 32'h01020304;
        end else begin
            tb_dm[0] = $urandom;
            tb_dm[1] = $urandom;
        end
        restart(1'b1, 1'b1);
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            if (fixed && i == 7) begin
                n_checks++; if (DM_Done !== 1'b0) begin n_fail++; $display("FAIL dump_done_early: got %b expected 0", DM_Done); end
            end
            exp = 8'(tb_dm[i / 4] >> (8 * (i % 4)));
            tx_get_byte(b, t0, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL dump_frame%0d: got malformed frame expected valid frame", i); end
            n_checks++; if (b !== exp) begin n_fail++; $display("FAIL dump_byte%0d: got %h expected %h", i, b, exp); end
            if (i > 0) begin
                n_checks++; if (t0 - t_prev != FRAME_BITS * CPB) begin
                    n_fail++; $display("FAIL dump_spacing%0d: got %0d cycles expected %0d", i, t0 - t_prev, FRAME_BITS * CPB);
                end
            end
            t_prev = t0;
        end
        repeat (CPB) @(negedge clk);
        n_checks++; if (DM_Done !== 1'b1) begin n_fail++; $display("FAIL dump_done: got %b expected 1", DM_Done); end
        n_checks++; if (address !== '0) begin n_fail++; $display("FAIL dump_addr_end: got %0d expected 0", address); end
        n_checks++; if (q_data.size() != 0) begin n_fail++; $display("FAIL dump_strobes: got %0d expected 0", q_data.size()); end
        for (int i = 0; i < 4 * CPB; i++) begin
            @(negedge clk);
            if (Tx_Serial !== 1'b1) zeros++;
        end
        n_checks++; if (zeros != 0) begin n_fail++; $display("FAIL dump_tx_idle: got %0d low cycles expected 0", zeros); end
    endtask

    task automatic test_unsupported();
        int zeros = 0;
        restart(1'b1, 1'b0);
        for (int i = 0; i < 6 * CPB; i++) begin
            @(negedge clk);
            if (Tx_Serial !== 1'b1) zeros++;
        end
        n_checks++; if (zeros != 0) begin n_fail++; $display("FAIL unsup_tx: got %0d low cycles expected 0", zeros); end
        n_checks++; if (address !== '0) begin n_fail++; $display("FAIL unsup_addr: got %0d expected 0", address); end
        n_checks++; if ({IM_Done, DM_Done} !== 2'b01) begin n_fail++; $display("FAIL unsup_flags: got %b expected 01", {IM_Done, DM_Done}); end
        n_checks++; if (q_data.size() != 0) begin n_fail++; $display("FAIL unsup_strobes: got %0d expected 0", q_data.size()); end
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        ram_id    = 1'b0;
        Rx_Serial = 1'b1;
        tb_dm[0]  = '0;
        tb_dm[1]  = '0;
        @(negedge clk);
        test_reset("reset_init");
        test_load_im();
        test_framing();
        test_glitch();
        test_abort();
        test_random_load();
        test_reset_mid_dump();
        test_dump(1'b1);
        test_dump(1'b0);
        test_unsupported();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
